bits_regs_mc: RTL and testbench
===============================

Name: bits_regs_mc

Overview:
APB3 register block for a bank of NUM_CH independent BITS decoder cores. Each core gets its own control, length and result registers. A per-channel IDLE/BUSY/DONE state machine owns the start/done handshake. A shared interrupt status/enable pair with write-1-to-clear semantics drives a single irq line. The block sits between the APB interconnect and the BITS core array.

Parameters:
NUM_CH, 2, number of BITS cores served (1..7)
LEN_W, 16, width of the expected_bytes field per channel (1..32)
SUM_W, 16, width of the version_sum field per channel (1..32)
VALUE_W, 64, width of the bits_value field per channel (33..64)

Ports:
clk  input  1  system clock
resetB  input  1  reset, asynchronous, active-low
paddr  input  8  APB byte address; bits [1:0] ignored
psel  input  1  APB select
penable  input  1  APB enable (access phase)
pwrite  input  1  APB write when 1
pwdata  input  32  APB write data
pready  output  1  APB ready; tied 1
prdata  output  32  APB read data
pslverr  output  1  APB error, valid during access phase
start  output  NUM_CH  one-cycle start pulse per core
abort  output  NUM_CH  one-cycle abort pulse per core
expected_bytes  output  NUM_CH*LEN_W  per-core length; channel c at [c*LEN_W +: LEN_W]
done  input  NUM_CH  per-core completion pulse
version_sum  input  NUM_CH*SUM_W  per-core result, packed the same way
bits_value  input  NUM_CH*VALUE_W  per-core result, packed the same way
irq  output  1  level interrupt = |(irq_status & irq_en)

Behaviour:
- Access cycle: wr = psel&penable&pwrite; rd = psel&penable&~pwrite. Writes take effect at the clk edge ending the access phase. Zero wait states.
- Channel c register base = c*0x20:
  - +0x00 CTRL (W): bit0 start, bit1 abort; reads 0.
  - +0x04 LEN (RW): [LEN_W-1:0].
  - +0x08 STATUS (RO): bit0 busy, bit1 done.
  - +0x0C VSUM (RO).
  - +0x10 VALUE_HI (RO): value[VALUE_W-1:32], zero-extended.
  - +0x14 VALUE_LO (RO): value[31:0].
- Global registers:
  - 0xE0 IRQ_STATUS: bit c = channel c done event; write-1-to-clear.
  - 0xE4 IRQ_EN (RW): [NUM_CH-1:0].
- Per-channel FSM, states IDLE/BUSY/DONE:
  - IDLE or DONE + CTRL write with bit0=1 -> BUSY. start[c]=1 the next cycle. VSUM and VALUE cleared to 0 in the same edge.
  - BUSY + done[c] -> DONE. Latch version_sum and bits_value; set irq_status[c].
  - BUSY + CTRL write with bit1=1 -> IDLE; abort[c]=1 the next cycle; latched results unchanged.
  - done[c] while IDLE/DONE: ignored (no latch, no irq).
- Start and abort bits both 1 in one write: abort wins if BUSY, otherwise start wins.
- pslverr=1 (write has no effect; read returns 0) when:
  - the address is unmapped, or channel index >= NUM_CH;
  - start is written while BUSY;
  - LEN is written while BUSY.
- pslverr is 0 outside the access phase. prdata is 0 when rd=0.
- Simultaneous done[c] and IRQ_STATUS W1C of bit c in the same cycle: set wins.
- Reset values: start=0, abort=0, expected_bytes=0, irq_status=0, irq_en=0, all FSMs IDLE, latched results 0, irq=0, prdata=0, pslverr=0.
- Reset asserted mid-operation: every channel returns to IDLE immediately; any done pulse arriving later is ignored.
- Reads are side-effect free.

Decomposition:
- Package bits_regs_pkg holds:
  - offset constants CTRL/LEN/STATUS/VSUM/VALUE_HI/VALUE_LO/IRQ_STATUS/IRQ_EN;
  - CH_STRIDE=0x20;
  - state encodings ST_IDLE=2'd0, ST_BUSY=2'd1, ST_DONE=2'd2.
- Sub-module bits_regs_chan, generated NUM_CH times. It holds one channel's FSM, LEN register, result latches and error decode. The top level does the address decode, the prdata mux, and the IRQ registers.

Test Plan:
- Reset, then read every mapped register -> all read 0; irq=0; pready=1.
- ch0: write LEN=0x0010, write CTRL=0x1 -> start[0] pulses exactly 1 cycle; STATUS=0x1. Drive done[0] with vsum=0x0031, value=0x0000_0001_0000_0002 -> STATUS=0x2, VSUM=0x31, HI=0x1, LO=0x2.
- With IRQ_EN=0x2: ch1 completes -> IRQ_STATUS=0x2 and irq=1. Write IRQ_STATUS=0x2 -> irq=0 next cycle. Assert done in the same cycle as the W1C -> bit stays 1.
- ch0 BUSY: CTRL=0x1 -> pslverr=1, no start pulse. LEN write -> pslverr=1, LEN unchanged. CTRL=0x2 -> abort[0] pulse; STATUS=0x0.
- Access to 0x40 (channel 2 when NUM_CH=2) and to 0xF0 -> pslverr=1, read returns 0. done[1] pulse while IDLE -> results stay 0, irq stays 0.
- ch0 BUSY, then resetB low for 1 cycle mid-run -> STATUS=0. A later done[0] -> no latch.

Source files
------------

// File: rtl/bits_regs_pkg.sv
// Shared constants for the BITS decoder register bank: register offsets,
// channel stride and per-channel FSM encodings.
package bits_regs_pkg;

   localparam logic [4:0] OFF_CTRL     = 5'h00;
   localparam logic [4:0] OFF_LEN      = 5'h04;
   localparam logic [4:0] OFF_STATUS   = 5'h08;
   localparam logic [4:0] OFF_VSUM     = 5'h0C;
   localparam logic [4:0] OFF_VALUE_HI = 5'h10;
   localparam logic [4:0] OFF_VALUE_LO = 5'h14;

   localparam logic [7:0] ADDR_IRQ_STATUS = 8'hE0;
   localparam logic [7:0] ADDR_IRQ_EN     = 8'hE4;
   localparam logic [7:0] CH_STRIDE       = 8'h20;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/bits_regs_chan.sv
// One BITS core's register slice: start/abort handshake FSM, LEN register,
// result latches and per-channel access error decode.
//
//   state   | meaning
//   --------+-------------------------------------------------
//   IDLE    | no job; results hold last value (or 0 after reset)
//   BUSY    | core started, waiting for done or abort
//   DONE    | core finished, results latched
module bits_regs_chan
   import bits_regs_pkg::*;
#(
   parameter int LEN_W   = 16,
   parameter int SUM_W   = 16,
   parameter int VALUE_W = 64
) (
   input  logic               clk,
   input  logic               resetB,
   input  logic               sel,
   input  logic               wr,
   input  logic               rd,
   input  logic [4:0]         offs,
   input  logic [31:0]        wdata,
   output logic [31:0]        rdata,
   output logic               err,
   output logic               start,
   output logic               abort,
   output logic [LEN_W-1:0]   len,
   input  logic               done_in,
   input  logic [SUM_W-1:0]   vsum_in,
   input  logic [VALUE_W-1:0] value_in,
   output logic               done_evt
);

   state_e               state_q, state_d;
   logic                 start_q, start_d;
   logic                 abort_q, abort_d;
   logic [LEN_W-1:0]     len_q, len_d;
   logic [SUM_W-1:0]     vsum_q, vsum_d;
   logic [VALUE_W-1:0]   value_q, value_d;
   logic                 busy, wr_ctrl, wr_len, go, stop, latch, mapped;
   logic [63:0]          value_ext;
   logic                 unused_wdata;

   assign busy    = (state_q == ST_BUSY);
   assign wr_ctrl = sel & wr & (offs == OFF_CTRL);
   assign wr_len  = sel & wr & (offs == OFF_LEN);
   // When both bits are set, abort takes priority only while a job is running.
   assign stop    = wr_ctrl & wdata[1] & busy;
   assign go      = wr_ctrl & wdata[0] & ~busy;
   assign latch   = busy & done_in & ~stop;
   assign mapped  = offs inside {OFF_CTRL, OFF_LEN, OFF_STATUS, OFF_VSUM,
                                 OFF_VALUE_HI, OFF_VALUE_LO};
   assign err     = sel & (wr | rd) &
                    (~mapped | (wr_ctrl & wdata[0] & ~wdata[1] & busy) | (wr_len & busy));
   assign unused_wdata = ^wdata;

   always_ff @(posedge clk or negedge resetB) begin
      if (!resetB) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_DONE: if (go) state_d = ST_BUSY;
         ST_BUSY: begin
            if (stop)         state_d = ST_IDLE;
            else if (done_in) state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      start_d  = go;
      abort_d  = stop;
      done_evt = latch;
      len_d    = (wr_len & ~busy) ? wdata[LEN_W-1:0] : len_q;
      vsum_d   = vsum_q;
      value_d  = value_q;
      if (go) begin
         vsum_d  = '0;
         value_d = '0;
      end else if (latch) begin
         vsum_d  = vsum_in;
         value_d = value_in;
      end
   end

   always_ff @(posedge clk or negedge resetB) begin
      if (!resetB) begin
         start_q <= 1'b0;
         abort_q <= 1'b0;
         len_q   <= '0;
         vsum_q  <= '0;
         value_q <= '0;
      end else begin
         start_q <= start_d;
         abort_q <= abort_d;
         len_q   <= len_d;
         vsum_q  <= vsum_d;
         value_q <= value_d;
      end
   end

   assign start     = start_q;
   assign abort     = abort_q;
   assign len       = len_q;
   assign value_ext = 64'(value_q);

   always_comb begin
      rdata = '0;
      if (sel & rd) begin
         case (offs)
            OFF_LEN:      rdata = 32'(len_q);
            OFF_STATUS:   rdata = {30'd0, state_q == ST_DONE, busy};
            OFF_VSUM:     rdata = 32'(vsum_q);
            OFF_VALUE_HI: rdata = value_ext[63:32];
            OFF_VALUE_LO: rdata = value_ext[31:0];
            default:      rdata = '0;
         endcase
      end
   end

endmodule

// File: rtl/bits_regs_mc.sv
// APB3 register block for NUM_CH BITS decoder cores: address decode, read mux,
// shared W1C interrupt status and enable driving a single level irq.
module bits_regs_mc
   import bits_regs_pkg::*;
#(
   parameter int NUM_CH  = 2,
   parameter int LEN_W   = 16,
   parameter int SUM_W   = 16,
   parameter int VALUE_W = 64
) (
   input  logic                      clk,
   input  logic                      resetB,
   input  logic [7:0]                paddr,
   input  logic                      psel,
   input  logic                      penable,
   input  logic                      pwrite,
   input  logic [31:0]               pwdata,
   output logic                      pready,
   output logic [31:0]               prdata,
   output logic                      pslverr,
   output logic [NUM_CH-1:0]         start,
   output logic [NUM_CH-1:0]         abort,
   output logic [NUM_CH*LEN_W-1:0]   expected_bytes,
   input  logic [NUM_CH-1:0]         done,
   input  logic [NUM_CH*SUM_W-1:0]   version_sum,
   input  logic [NUM_CH*VALUE_W-1:0] bits_value,
   output logic                      irq
);

   localparam int CH_SHIFT = $clog2(CH_STRIDE);

   logic              wr, rd, glob, glob_err, hole_err, wr_stat, wr_en;
   logic [2:0]        chan_idx;
   logic [4:0]        offs;
   logic [7:0]        waddr;
   logic [31:0]       ch_rdata [NUM_CH];
   logic [NUM_CH-1:0] ch_err, done_evt;
   logic [NUM_CH-1:0] irq_status_q, irq_status_d;
   logic [NUM_CH-1:0] irq_en_q, irq_en_d;
   logic [31:0]       rd_mux;
   logic              unused_top;

   assign wr       = psel & penable & pwrite;
   assign rd       = psel & penable & ~pwrite;
   assign chan_idx = paddr[7:CH_SHIFT];
   assign offs     = {paddr[4:2], 2'b00};
   assign waddr    = {paddr[7:2], 2'b00};
   // The top stride slot (index 7) holds the global registers, never a channel.
   assign glob     = (chan_idx == 3'd7);
   assign glob_err = glob & (wr | rd) & (waddr != ADDR_IRQ_STATUS) & (waddr != ADDR_IRQ_EN);
   assign hole_err = ~glob & (wr | rd) & (32'(chan_idx) >= NUM_CH);
   assign wr_stat  = wr & (waddr == ADDR_IRQ_STATUS);
   assign wr_en    = wr & (waddr == ADDR_IRQ_EN);
   assign unused_top = ^{paddr[1:0], pwdata};

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      bits_regs_chan #(
         .LEN_W   (LEN_W),
         .SUM_W   (SUM_W),
         .VALUE_W (VALUE_W)
      ) u_chan (
         .clk      (clk),
         .resetB   (resetB),
         .sel      (chan_idx == 3'(c)),
         .wr       (wr),
         .rd       (rd),
         .offs     (offs),
         .wdata    (pwdata),
         .rdata    (ch_rdata[c]),
         .err      (ch_err[c]),
         .start    (start[c]),
         .abort    (abort[c]),
         .len      (expected_bytes[c*LEN_W +: LEN_W]),
         .done_in  (done[c]),
         .vsum_in  (version_sum[c*SUM_W +: SUM_W]),
         .value_in (bits_value[c*VALUE_W +: VALUE_W]),
         .done_evt (done_evt[c])
      );
   end

   // A core's done event wins over a same-cycle W1C of its bit.
   always_comb begin
      irq_status_d = irq_status_q;
      if (wr_stat) irq_status_d = irq_status_d & ~pwdata[NUM_CH-1:0];
      irq_status_d = irq_status_d | done_evt;
      irq_en_d     = wr_en ? pwdata[NUM_CH-1:0] : irq_en_q;
   end

   always_ff @(posedge clk or negedge resetB) begin
      if (!resetB) begin
         irq_status_q <= '0;
         irq_en_q     <= '0;
      end else begin
         irq_status_q <= irq_status_d;
         irq_en_q     <= irq_en_d;
      end
   end

   always_comb begin
      rd_mux = '0;
      for (int c = 0; c < NUM_CH; c++) rd_mux = rd_mux | ch_rdata[c];
      if (waddr == ADDR_IRQ_STATUS) rd_mux = 32'(irq_status_q);
      if (waddr == ADDR_IRQ_EN)     rd_mux = 32'(irq_en_q);
   end

   assign pslverr = (|ch_err) | glob_err | hole_err;
   assign prdata  = (rd & ~pslverr) ? rd_mux : '0;
   assign pready  = 1'b1;
   assign irq     = |(irq_status_q & irq_en_q);

endmodule

// File: tb/tb_bits_regs_mc.sv
// Directed bench for bits_regs_mc: scoreboard of expected values pushed at
// stimulus time and checked with immediate assertions when outputs are sampled.
module tb_bits_regs_mc;

   localparam int NUM_CH  = 2;
   localparam int LEN_W   = 16;
   localparam int SUM_W   = 16;
   localparam int VALUE_W = 64;

   logic                      clk = 1'b0;
   logic                      resetB;
   logic [7:0]                paddr;
   logic                      psel, penable, pwrite;
   logic [31:0]               pwdata;
   logic                      pready;
   logic [31:0]               prdata;
   logic                      pslverr;
   logic [NUM_CH-1:0]         start, abort, done;
   logic [NUM_CH*LEN_W-1:0]   expected_bytes;
   logic [NUM_CH*SUM_W-1:0]   version_sum;
   logic [NUM_CH*VALUE_W-1:0] bits_value;
   logic                      irq;

   bits_regs_mc #(.NUM_CH(NUM_CH), .LEN_W(LEN_W), .SUM_W(SUM_W), .VALUE_W(VALUE_W)) dut (
      .clk(clk), .resetB(resetB), .paddr(paddr), .psel(psel), .penable(penable),
      .pwrite(pwrite), .pwdata(pwdata), .pready(pready), .prdata(prdata),
      .pslverr(pslverr), .start(start), .abort(abort), .expected_bytes(expected_bytes),
      .done(done), .version_sum(version_sum), .bits_value(bits_value), .irq(irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [63:0] val;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   initial begin
      #2_000_000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic sb_push(input string tag, input logic [63:0] v);
      exp_t e;
      e.tag = tag;
      e.val = v;
      sb.push_back(e);
   endtask

   task automatic sb_check(input logic [63:0] obs);
      exp_t e;
      total++;
      if (sb.size() == 0) begin
         bad++;
         $error("FAIL sb_empty obs=%0h exp=entry", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.val)
         else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic apb(input logic [7:0] a, input logic we, input logic [31:0] d,
                      input logic [NUM_CH-1:0] dn, output logic [31:0] rdat, output logic err);
      @(posedge clk); #1;
      paddr = a; pwrite = we; pwdata = d; psel = 1'b1; penable = 1'b0;
      @(posedge clk); #1;
      penable = 1'b1; done = dn;
      @(negedge clk);
      rdat = prdata; err = pslverr;
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0; done = '0;
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic exp_err,
                     input logic [NUM_CH-1:0] dn = '0);
      logic [31:0] rdat;
      logic        err;
      sb_push($sformatf("wr_err@%02h", a), 64'(exp_err));
      apb(a, 1'b1, d, dn, rdat, err);
      sb_check(64'(err));
   endtask

   task automatic rd(input logic [7:0] a, input logic [31:0] exp_d, input logic exp_err = 1'b0);
      logic [31:0] rdat;
      logic        err;
      sb_push($sformatf("rd_data@%02h", a), 64'(exp_d));
      sb_push($sformatf("rd_err@%02h", a), 64'(exp_err));
      apb(a, 1'b0, 32'h0, '0, rdat, err);
      sb_check(64'(rdat));
      sb_check(64'(err));
   endtask

   task automatic now(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      sb_push(tag, exp_v);
      sb_check(obs);
   endtask

   task automatic pulse_done(input logic [NUM_CH-1:0] m);
      @(posedge clk); #1 done = m;
      @(posedge clk); #1 done = '0;
   endtask

   function automatic logic [7:0] ca(input int ch, input logic [7:0] off);
      return 8'(ch * 32) + off;
   endfunction

   initial begin
      resetB = 1'b0; paddr = '0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      pwdata = '0; done = '0; version_sum = '0; bits_value = '0;
      repeat (3) @(posedge clk);
      #1 resetB = 1'b1;
      @(negedge clk);
      now("rst_irq", 64'(irq), 64'd0);
      now("rst_pready", 64'(pready), 64'd1);
      now("rst_start", 64'(start), 64'd0);
      now("rst_abort", 64'(abort), 64'd0);
      now("rst_len", 64'(expected_bytes), 64'd0);
      now("rst_prdata", 64'(prdata), 64'd0);
      now("rst_pslverr", 64'(pslverr), 64'd0);
      for (int ch = 0; ch < NUM_CH; ch++)
         for (int o = 0; o < 6; o++) rd(ca(ch, 8'(o * 4)), 32'h0);
      rd(8'hE0, 32'h0);
      rd(8'hE4, 32'h0);

      // channel 0 normal run
      wr(ca(0, 8'h04), 32'h0000_0010, 1'b0);
      rd(ca(0, 8'h04), 32'h10);
      now("len0_port", 64'(expected_bytes[15:0]), 64'h10);
      wr(ca(0, 8'h00), 32'h1, 1'b0);
      @(negedge clk);
      now("start0_on", 64'(start), 64'b01);
      @(negedge clk);
      now("start0_off", 64'(start), 64'b00);
      rd(ca(0, 8'h08), 32'h1);
      version_sum[15:0] = 16'h0031;
      bits_value[63:0]  = 64'h0000_0001_0000_0002;
      pulse_done(2'b01);
      rd(ca(0, 8'h08), 32'h2);
      rd(ca(0, 8'h0C), 32'h31);
      rd(ca(0, 8'h10), 32'h1);
      rd(ca(0, 8'h14), 32'h2);
      @(negedge clk);
      now("irq_masked", 64'(irq), 64'd0);
      rd(8'hE0, 32'h1);
      wr(8'hE0, 32'h1, 1'b0);
      rd(8'hE0, 32'h0);

      // channel 1 with interrupt enabled
      wr(8'hE4, 32'h2, 1'b0);
      rd(8'hE4, 32'h2);
      wr(ca(1, 8'h00), 32'h1, 1'b0);
      @(negedge clk);
      now("start1_on", 64'(start), 64'b10);
      version_sum[31:16]  = 16'h0055;
      bits_value[127:64]  = 64'hDEAD_BEEF_0123_4567;
      pulse_done(2'b10);
      rd(8'hE0, 32'h2);
      @(negedge clk);
      now("irq_set", 64'(irq), 64'd1);
      rd(ca(1, 8'h0C), 32'h55);
      rd(ca(1, 8'h10), 32'hDEAD_BEEF);
      rd(ca(1, 8'h14), 32'h0123_4567);
      wr(8'hE0, 32'h2, 1'b0);
      @(negedge clk);
      now("irq_clr", 64'(irq), 64'd0);
      wr(ca(1, 8'h00), 32'h1, 1'b0);
      version_sum[31:16] = 16'h0077;
      wr(8'hE0, 32'h2, 1'b0, 2'b10);
      rd(8'hE0, 32'h2);
      @(negedge clk);
      now("irq_set_wins", 64'(irq), 64'd1);
      rd(ca(1, 8'h0C), 32'h77);
      wr(8'hE0, 32'h2, 1'b0);
      rd(8'hE0, 32'h0);

      // channel 0 busy-state errors and abort
      wr(ca(0, 8'h00), 32'h1, 1'b0);
      rd(ca(0, 8'h0C), 32'h0);
      rd(ca(0, 8'h10), 32'h0);
      wr(ca(0, 8'h00), 32'h1, 1'b1);
      @(negedge clk);
      now("no_restart", 64'(start), 64'b00);
      wr(ca(0, 8'h04), 32'h99, 1'b1);
      rd(ca(0, 8'h04), 32'h10);
      wr(ca(0, 8'h00), 32'h2, 1'b0);
      @(negedge clk);
      now("abort0_on", 64'(abort), 64'b01);
      @(negedge clk);
      now("abort0_off", 64'(abort), 64'b00);
      rd(ca(0, 8'h08), 32'h0);
      wr(ca(0, 8'h00), 32'h3, 1'b0);
      rd(ca(0, 8'h08), 32'h1);
      wr(ca(0, 8'h00), 32'h3, 1'b0);
      rd(ca(0, 8'h08), 32'h0);

      // unmapped accesses and ignored done
      rd(8'h40, 32'h0, 1'b1);
      wr(8'h40, 32'h1, 1'b1);
      rd(8'hF0, 32'h0, 1'b1);
      rd(ca(0, 8'h18), 32'h0, 1'b1);
      rd(8'hE8, 32'h0, 1'b1);
      version_sum[31:16] = 16'h0012;
      pulse_done(2'b10);
      rd(ca(1, 8'h0C), 32'h77);
      rd(8'hE0, 32'h0);

      // reset in the middle of a run
      wr(ca(0, 8'h00), 32'h1, 1'b0);
      rd(ca(0, 8'h08), 32'h1);
      @(posedge clk); #1 resetB = 1'b0;
      @(negedge clk);
      now("rst_mid_start", 64'(start), 64'd0);
      @(posedge clk); #1 resetB = 1'b1;
      rd(ca(0, 8'h08), 32'h0);
      rd(ca(0, 8'h04), 32'h0);
      version_sum = {16'h0099, 16'h0088};
      bits_value  = {64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888};
      pulse_done(2'b11);
      rd(ca(0, 8'h0C), 32'h0);
      rd(ca(0, 8'h14), 32'h0);
      rd(ca(1, 8'h0C), 32'h0);
      rd(8'hE0, 32'h0);
      @(negedge clk);
      now("irq_after_rst", 64'(irq), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
